// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad row decoder.
//   kp_state_t : debounce state machine states
//   KEY_MAP    : 16-entry key code table indexed {row, col}
//   key_lookup : row/column to key code
//   prio_row   : lowest set row wins when several rows are active
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row-major: entries 0..3 are row 0, columns 0..3.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1,     4'h2, 4'h3,     4'hA,
    4'h4,     4'h5, 4'h6,     4'hB,
    4'h7,     4'h8, 4'h9,     4'hC,
    KEY_STAR, 4'h0, KEY_HASH, 4'hD
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  function automatic logic [1:0] prio_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (rows[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/kp_sync.sv
// N-stage, W-bit flop chain with async active-low clear. Used both as the
// row_in metastability synchronizer and as the matching column_index delay
// line, so both streams arrive with identical latency.
//   clk  : clock
//   rst  : async active-low clear
//   din  : input word
//   dout : din delayed by N cycles
module kp_sync #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [N-1:0][W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q[0] <= din;
      for (int i = 1; i < N; i++) q[i] <= q[i-1];
    end
  end

  assign dout = q[N-1];

endmodule

// File: rtl/keypad_row_decoder.sv
// Keypad row decoder: samples the 4 row lines against the scanned column,
// debounces a press/release over consecutive scans of the key's own column
// and emits a one-cycle strobe with the key code on each accepted press.
//   slow_clk     : scan clock shared with the column shift register
//   rst          : async active-low reset
//   column_index : column currently driven
//   row_in       : raw row lines, 1 = pressed (asynchronous)
//   key_code     : last accepted key code, held until the next press
//   key_valid    : one-cycle pulse when key_code updates
//   key_held     : high from press acceptance until release acceptance
module keypad_row_decoder
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [1:0] column_index,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  logic [1:0]    col_d;
  kp_state_t     state;
  logic [1:0]    cand_row, cand_col;
  logic [CW-1:0] cnt, cnt_inc;
  logic          col_hit, row_hit;

  kp_sync #(.N(SYNC_STAGES), .W(4)) u_row_sync (
    .clk(slow_clk), .rst(rst), .din(row_in), .dout(row_s)
  );

  kp_sync #(.N(SYNC_STAGES), .W(2)) u_col_dly (
    .clk(slow_clk), .rst(rst), .din(column_index), .dout(col_d)
  );

  // Only scans of the locked column count; everything else is ignored.
  assign col_hit = (col_d == cand_col);
  assign row_hit = row_s[cand_row];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand_row  <= 2'd0;
      cand_col  <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (row_s != 4'h0) begin
            cand_row <= prio_row(row_s);
            cand_col <= col_d;
            if (DEBOUNCE_SCANS == 1) begin
              state     <= PRESSED;
              cnt       <= '0;
              key_code  <= key_lookup(prio_row(row_s), col_d);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else begin
              state <= DEB_PRESS;
              cnt   <= CW'(1);
            end
          end
        end
        DEB_PRESS: begin
          if (col_hit) begin
            if (row_hit) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_code  <= key_lookup(cand_row, cand_col);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else begin
              // A bounce aborts the press entirely.
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        PRESSED: begin
          if (col_hit && !row_hit) begin
            state <= DEB_RELEASE;
            cnt   <= CW'(1);
          end
        end
        DEB_RELEASE: begin
          if (col_hit) begin
            if (!row_hit) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_row_decoder.md
Name: keypad_row_decoder

Overview:
- Consumes the column scan produced by the column shift register, with both blocks on the same slow_clk.
- Samples the 4 keypad row lines and debounces a pressed key across successive scans of its column.
- Emits a 4-bit key code with a one-cycle valid strobe for the downstream operand-capture logic of the Booth multiplier.
- One press gives exactly one strobe. There is no auto-repeat.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on row_in and matching delay stages on column_index.
- DEBOUNCE_SCANS, 4: number of consecutive scans of the key's column that must agree before a press or a release is accepted.

Ports:
- slow_clk, input, 1: scan clock, the same clock that drives the column shift register.
- rst, input, 1: asynchronous active-low reset.
- column_index, input, 2: index of the column currently driven, from the column shift register.
- row_in, input, 4: keypad row lines. 1 = key pressed in the driven column. Asynchronous to slow_clk.
- key_code, output, 4: code of the last accepted key. Holds its value until the next accepted press.
- key_valid, output, 1: one-cycle pulse in the cycle key_code updates.
- key_held, output, 1: 1 from acceptance until the release is accepted.

Behaviour:
- Reset: rst low asynchronously clears all flops.
  - key_code=4'h0, key_valid=0, key_held=0, state=IDLE.
  - Synchronizer and column-delay flops reset to 0. The debounce counter resets to 0.
- Alignment: row_in passes through SYNC_STAGES flops. column_index passes through SYNC_STAGES flops in parallel. Every decision uses the pair (row_s, col_d) sampled in the same cycle.
- Row priority: when several row_s bits are set, the lowest row index wins. Rows in other columns are ignored while a key is locked.
- Key map, row r / column c → code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
  - Encoding: digits 0–9 = 4'h0–4'h9, A–D = 4'hA–4'hD, * = 4'hE, # = 4'hF.
- States:
  - IDLE:
    - row_s != 0 → latch cand_row (priority row) and cand_col = col_d, set cnt=1, go to DEB_PRESS.
    - Special case DEBOUNCE_SCANS=1: go directly to PRESSED and raise key_valid.
  - DEB_PRESS: act only in cycles where col_d == cand_col. Other columns do not count.
    - row_s[cand_row]=1 → cnt+1.
    - When cnt reaches DEBOUNCE_SCANS → state PRESSED. In that same cycle key_code is set to map(cand_row, cand_col), key_valid=1 and key_held=1.
    - row_s[cand_row]=0 → return to IDLE, cnt=0. A bounce aborts the press.
  - PRESSED: act only in cycles with col_d == cand_col.
    - row_s[cand_row]=0 → cnt=1, go to DEB_RELEASE.
  - DEB_RELEASE: act only in cycles with col_d == cand_col.
    - row_s[cand_row]=0 → cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE, key_held=0.
    - row_s[cand_row]=1 → back to PRESSED, cnt=0.
- Timing: key_valid is high for exactly 1 cycle per accepted press. With a 4-column scan, press-to-strobe latency is SYNC_STAGES + 4·(DEBOUNCE_SCANS−1) + 1 cycles, ±3 cycles of scan phase.
- Width: cnt is $clog2(DEBOUNCE_SCANS+1) bits and saturates. It never wraps.
- Second key pressed while PRESSED: ignored, no strobe. After the first key's release is accepted, a key still held is detected from IDLE as a new press.
- Reset asserted mid-debounce or while PRESSED: all state clears immediately and no strobe is produced. After reset release the block restarts in IDLE.
- column_index repeating or skipping values: tolerated. Only cycles with col_d == cand_col advance the state machine.

Decomposition:
- Package keypad_pkg:
  - typedef enum kp_state_t {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE}.
  - 16-entry key-map constant array, indexed {row, col}.
  - Localparams KEY_STAR=4'hE and KEY_HASH=4'hF.
- Sub-module kp_sync: a parameterised N-stage, W-bit synchronizer with async active-low clear.
  - One instance for row_in, plain flops, W=4.
  - One instance reused as the column_index delay line, W=2.

Test Plan:
- Reset: hold rst=0 with row_in=4'hF toggling → key_code=0, key_valid=0, key_held=0 throughout. After release, IDLE until row_in changes.
- Clean press of key "5" (r1, c1): assert row_in[1] only while column_index==1, for 6 scans → exactly one key_valid pulse with key_code=4'h5, and key_held=1.
  - Then drop row_in for 4 scans → key_held=0 and no further strobe.
- Bounce: key "#" (r3, c2) present for 2 scans, absent 1 scan, then present for 4 scans → a single strobe with key_code=4'hF, occurring after the 4th consecutive scan only.
- Multi-row priority: rows 0 and 2 set on column 3 → key_code=4'hA, not 4'hC.
  - With "A" held, press "1" (r0, c0) → no strobe.
  - Release "A" → after the release debounce, "1" strobes with key_code=4'h1.
- Reset mid-operation: press "0" (r3, c1) and assert rst after 2 scans, with rst low for 3 cycles → no strobe.
  - Key still held after reset → a full debounce from IDLE, then a strobe with key_code=4'h0.
- Release bounce: while "9" is held, drop row_in for 2 scans, restore it for 1 scan, then drop it for 4 scans → key_held stays 1 until the final 4-scan drop, and no second strobe occurs.
